// File: rtl/ptw_mem_responder.sv
// Responder for Sv32 page-table-walk reads from the I-side and D-side MMUs.
// Round-robin arbitration, one 32-bit bus read per request, single-cycle ack.
module ptw_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ptw_req,
    input  logic [31:0] i_ptw_addr,
    output logic [31:0] i_ptw_data,
    output logic        i_ptw_ack,
    input  logic        d_ptw_req,
    input  logic [31:0] d_ptw_addr,
    output logic [31:0] d_ptw_data,
    output logic        d_ptw_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        err_pulse
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 0: I-MMU, 1: D-MMU
    logic              last_grant_q, last_grant_d; // 0: I-MMU, 1: D-MMU
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [31:0]       i_data_q, d_data_q;

    logic              grant_i;
    logic [31:0]       sel_addr;
    logic              owner_req;
    logic              resp_ok;

    assign grant_i   = i_ptw_req && (!d_ptw_req || last_grant_q);
    assign sel_addr  = grant_i ? i_ptw_addr : d_ptw_addr;
    assign owner_req = owner_q ? d_ptw_req : i_ptw_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        drop_d       = drop_q;
        unique case (state_q)
            StIdle: begin
                if (i_ptw_req || d_ptw_req) begin
                    owner_d      = !grant_i;
                    last_grant_d = !grant_i;
                    addr_d       = sel_addr;
                    cnt_d        = '0;
                    drop_d       = 1'b0;
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = StResp;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (!owner_req) drop_d = 1'b1;
                if (mem_gnt) begin
                    state_d = StWait;
                end else if (cnt_q == TmoLast) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (!owner_req) drop_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = StResp;
                    rdata_d = mem_err ? 32'h0 : mem_rdata;
                    err_d   = mem_err;
                end else if (cnt_q == TmoLast) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
            if (i_ptw_ack) i_data_q <= rdata_q;
            if (d_ptw_ack) d_data_q <= rdata_q;
        end
    end

    // An owner that withdrew its request mid-transaction gets no ack.
    assign resp_ok    = (state_q == StResp) && !drop_q;
    assign i_ptw_ack  = resp_ok && !owner_q;
    assign d_ptw_ack  = resp_ok && owner_q;
    assign i_ptw_data = i_ptw_ack ? rdata_q : i_data_q;
    assign d_ptw_data = d_ptw_ack ? rdata_q : d_data_q;
    assign mem_req    = (state_q == StReq);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign busy       = (state_q != StIdle);
    assign err_pulse  = (state_q == StResp) && err_q;

endmodule

// File: doc/ptw_mem_responder.md
Name: ptw_mem_responder

Overview:
- Responder end of the Sv32 page-table-walk (PTW) request interface.
- Serves two MMU initiators: the instruction-side MMU (port prefix i_) and the data-side MMU (port prefix d_).
- Arbitrates between them round-robin, performs one 32-bit read per request on the shared memory bus, and returns the PTE with a single-cycle ack.
- Bus errors, timeouts and misaligned addresses return PTE = 0; V=0 makes the MMU raise a page fault.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before the transaction is abandoned; legal range 1..255.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES <= 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_ptw_req  in  1  I-MMU request; held with a stable address until ack.
- i_ptw_addr  in  32  I-MMU PTE physical address.
- i_ptw_data  out  32  PTE returned to the I-MMU.
- i_ptw_ack  out  1  one-cycle response pulse to the I-MMU.
- d_ptw_req  in  1  D-MMU request.
- d_ptw_addr  in  32  D-MMU PTE physical address.
- d_ptw_data  out  32  PTE returned to the D-MMU.
- d_ptw_ack  out  1  one-cycle response pulse to the D-MMU.
- mem_req  out  1  bus read request; held until mem_gnt.
- mem_addr  out  32  bus word address, always {addr[31:2],2'b00}.
- mem_gnt  in  1  bus accepted the request this cycle.
- mem_rvalid  in  1  read data valid; earliest one cycle after gnt, exactly one per gnt.
- mem_rdata  in  32  read data.
- mem_err  in  1  bus error, qualified by mem_rvalid.
- busy  out  1  state != IDLE.
- err_pulse  out  1  one-cycle pulse per error response (misalign, bus error, timeout).

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_req=0, mem_addr=0.
  - i_/d_ptw_ack=0, i_/d_ptw_data=0.
  - busy=0, err_pulse=0.
  - last_grant=D, so I wins the first conflict.
  - timeout counter=0.
- All outputs are registered or decoded from registered state. There is no combinational path from any req input to any output.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Samples i_ptw_req and d_ptw_req.
  - Only one requesting: grant it.
  - Both requesting: grant the one that is not last_grant.
  - On grant: latch owner and address, update last_grant, clear the counter.
  - addr[1:0]!=0: go to RESP with rdata_q=0 and err_q=1; no bus access.
  - Otherwise: go to REQ.
- REQ:
  - mem_req=1, mem_addr=latched address.
  - mem_gnt=1: go to WAIT (mem_req drops the next cycle).
  - Counter increments each cycle.
- WAIT:
  - mem_rvalid=1: go to RESP. rdata_q = mem_err ? 0 : mem_rdata; err_q = mem_err.
  - Counter increments each cycle.
- Timeout, in REQ or WAIT: when the counter reaches TIMEOUT_CYCLES-1 with no gnt/rvalid that cycle, go to RESP with rdata_q=0 and err_q=1. In REQ, mem_req deasserts.
- RESP:
  - For exactly one cycle, the owner's ack=1 and the owner's ptw_data=rdata_q.
  - err_pulse=err_q.
  - Then go to IDLE.
  - Requests present during RESP are not sampled. The initiator may present a new address combinationally in the ack cycle; it is picked up in the following IDLE cycle.
- Minimum latency: req seen in IDLE at cycle 0 → mem_req at cycle 1 (gnt same cycle) → rvalid cycle 2 → ack cycle 3.
- Misaligned latency: ack at cycle 1.
- Non-owner: ack=0 always; its ptw_data holds its last returned value.
- ptw_data outputs hold their value after ack; initiators use the data only on ack.
- Owner drops req before RESP: the transaction completes on the bus normally, ack is suppressed in RESP, and err_pulse still fires if err_q.
- mem_gnt or mem_rvalid outside REQ/WAIT: ignored. This includes a late rvalid after a WAIT timeout.
- mem_gnt and mem_rvalid in the same cycle while in REQ: rvalid ignored (rvalid is only valid from the cycle after gnt).
- Simultaneous I/D requests back-to-back: strict alternation I, D, I, D…
- Async reset mid-transaction: immediate return to reset values and mem_req drops. The bus side tolerates an abandoned request.

Test Plan:
- I-only req, addr 0x8000_1004; gnt at cycle 1, rvalid at cycle 2 with rdata 0x2000_0C01 → mem_addr=0x8000_1004; i_ptw_ack pulses at cycle 3 with i_ptw_data=0x2000_0C01; d_ptw_ack stays 0; busy high cycles 1-3.
- I and D both req in IDLE after reset, addrs 0x100 and 0x200 → I served first (mem_addr 0x100), then D (0x200); a further joint request is served I first again; each ack is exactly one cycle.
- Wait states: gnt held low 5 cycles, rvalid 3 cycles after gnt → mem_req high 6 cycles with a stable address; ack 1 cycle after rvalid with the correct data.
- rvalid with mem_err=1 and rdata 0xFFFF_FFFF → ptw_data=0, ack=1, err_pulse=1 in the same cycle.
- Misaligned addr 0x8000_1002 → no mem_req; ack at cycle 1 with data 0 and err_pulse=1.
- TIMEOUT_CYCLES=4 with gnt never asserted → mem_req high 4 cycles, then ack with data 0 and err_pulse; a later stray rvalid is ignored. Separately, rst asserted in WAIT → all outputs return to 0 asynchronously.
